// File: rtl/conv_pkg.sv
// Shared scheduler types: FSM state encoding and the stall decode.
// No latency or backpressure of its own; used by conv_sched.
package conv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_CTRL_REQ,
        ST_CTRL_ACK,
        ST_CTRL_RUN,
        ST_CIM_RUN,
        ST_FUNC_REQ,
        ST_FUNC_ACK,
        ST_FUNC_RUN,
        ST_DONE
    } conv_state_t;

    // Only IDLE and FILL let the previous layer write into the ibufs.
    function automatic logic state_stalls(input conv_state_t s);
        return !(s == ST_IDLE || s == ST_FILL);
    endfunction

endpackage

// File: rtl/conv_pix_cnt.sv
// Raster col/row counter for accepted pixels; win_vld is combinational from the current position.
// Advances one step per adv cycle, clr wins over adv; no backpressure of its own.
module conv_pix_cnt #(
    parameter int img_width  = 28,
    parameter int kernel_dim = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic win_vld
);

    localparam int cw = (img_width > 1) ? $clog2(img_width) : 1;

    logic [cw-1:0] col;
    logic [cw-1:0] row;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (col == cw'(img_width - 1)) begin
                col <= '0;
                row <= (row == cw'(img_width - 1)) ? '0 : row + cw'(1);
            end else begin
                col <= col + cw'(1);
            end
        end
    end

    // The pixel at this position is the bottom-right corner of a full window.
    assign win_vld = (row >= cw'(kernel_dim - 1)) && (col >= cw'(kernel_dim - 1));

endmodule

// File: rtl/conv_sched.sv
// Convolution layer scheduler: ibuf fill -> ctrl -> crossbar -> func per window, counted per frame.
// All outputs registered (one cycle from inputs); o_stall holds the previous layer off outside FILL.
module conv_sched
    import conv_pkg::*;
#(
    parameter int img_width  = 28,
    parameter int kernel_dim = 5,
    localparam int out_dim   = img_width - kernel_dim + 1,
    localparam int cnt_w     = $clog2(out_dim * out_dim + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_pixel_we,
    output logic             o_stall,
    input  logic             i_ctrl_busy,
    input  logic             i_cim_busy,
    input  logic             i_func_busy,
    input  logic             i_next_busy,
    output logic             o_ctrl_start,
    output logic             o_func_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overrun,
    output logic [cnt_w-1:0] o_win_cnt
);

    conv_state_t state;
    conv_state_t nxt;

    logic accept;
    logic win_vld;
    logic frame_go;
    logic win_fin;

    // o_busy/o_stall are registered decodes of state, so this matches "state == FILL".
    assign accept   = i_pixel_we && o_busy && !o_stall;
    assign frame_go = (state == ST_IDLE) && i_start;
    assign win_fin  = (state == ST_FUNC_RUN) && !i_func_busy;

    conv_pix_cnt #(
        .img_width  (img_width),
        .kernel_dim (kernel_dim)
    ) u_pix_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_go),
        .adv     (accept),
        .win_vld (win_vld)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:     if (i_start)                      nxt = ST_FILL;
            ST_FILL:     if (accept && win_vld)            nxt = ST_CTRL_REQ;
            ST_CTRL_REQ: if (!i_ctrl_busy && !i_func_busy) nxt = ST_CTRL_ACK;
            ST_CTRL_ACK: if (i_ctrl_busy)                  nxt = ST_CTRL_RUN;
            ST_CTRL_RUN: if (!i_ctrl_busy)                 nxt = ST_CIM_RUN;
            ST_CIM_RUN:  if (!i_cim_busy)                  nxt = ST_FUNC_REQ;
            ST_FUNC_REQ: if (!i_next_busy && !i_func_busy) nxt = ST_FUNC_ACK;
            ST_FUNC_ACK: if (i_func_busy)                  nxt = ST_FUNC_RUN;
            ST_FUNC_RUN: begin
                if (!i_func_busy)
                    nxt = (o_win_cnt + cnt_w'(1) == cnt_w'(out_dim * out_dim)) ? ST_DONE : ST_FILL;
            end
            ST_DONE:                                       nxt = ST_IDLE;
            default:                                       nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_stall      <= 1'b0;
            o_ctrl_start <= 1'b0;
            o_func_start <= 1'b0;
            o_done       <= 1'b0;
            o_overrun    <= 1'b0;
            o_win_cnt    <= '0;
        end else begin
            state        <= nxt;
            o_busy       <= (nxt != ST_IDLE);
            o_stall      <= state_stalls(nxt);
            o_ctrl_start <= (state == ST_CTRL_REQ) && (nxt == ST_CTRL_ACK);
            o_func_start <= (state == ST_FUNC_REQ) && (nxt == ST_FUNC_ACK);
            o_done       <= (nxt == ST_DONE);
            o_overrun    <= o_overrun || (i_pixel_we && !accept);
            if (frame_go)
                o_win_cnt <= '0;
            else if (win_fin)
                o_win_cnt <= o_win_cnt + cnt_w'(1);
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Directed frame sequence with randomized gaps and busy responders, checked against a raster window model.
module tb_conv_sched;

    localparam int W    = 6;
    localparam int K    = 3;
    localparam int OD   = W - K + 1;
    localparam int NWIN = OD * OD;
    localparam int NPIX = W * W;
    localparam int CW   = $clog2(NWIN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_pixel_we = 1'b0;
    logic          i_ctrl_busy = 1'b0;
    logic          i_cim_busy = 1'b0;
    logic          i_func_busy = 1'b0;
    logic          i_next_busy = 1'b0;
    logic          o_stall, o_ctrl_start, o_func_start, o_busy, o_done, o_overrun;
    logic [CW-1:0] o_win_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int n_ctrl   = 0;
    int n_func   = 0;
    int n_done   = 0;
    bit cim_hold = 1'b0;

    always #5 clk = ~clk;

    conv_sched #(
        .img_width  (W),
        .kernel_dim (K)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_pixel_we   (i_pixel_we),
        .o_stall      (o_stall),
        .i_ctrl_busy  (i_ctrl_busy),
        .i_cim_busy   (i_cim_busy),
        .i_func_busy  (i_func_busy),
        .i_next_busy  (i_next_busy),
        .o_ctrl_start (o_ctrl_start),
        .o_func_start (o_func_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overrun    (o_overrun),
        .o_win_cnt    (o_win_cnt)
    );

    // Windows completed before raster pixel p arrives: count of earlier pixels that close a KxK window.
    function automatic int exp_wins(input int p);
        int n = 0;
        for (int i = 0; i < p; i++)
            if ((i / W) >= K - 1 && (i % W) >= K - 1) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},    o_busy,       0);
        chk({tag, "_stall"},   o_stall,      0);
        chk({tag, "_done"},    o_done,       0);
        chk({tag, "_ctrl_st"}, o_ctrl_start, 0);
        chk({tag, "_func_st"}, o_func_start, 0);
        chk({tag, "_overrun"}, o_overrun,    0);
        chk({tag, "_win_cnt"}, o_win_cnt,    0);
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_busy",    o_busy,    1);
        chk("start_stall",   o_stall,   0);
        chk("start_win_cnt", o_win_cnt, 0);
    endtask

    task automatic send_pixel(input int p);
        int k;
        for (k = 0; k < 500 && !(o_busy === 1'b1 && o_stall === 1'b0); k++) @(negedge clk);
        chk("fill_wait", (o_busy === 1'b1 && o_stall === 1'b0), 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("win_cnt_before_pix", o_win_cnt, exp_wins(p));
        i_pixel_we = 1'b1;
        @(negedge clk);
        i_pixel_we = 1'b0;
    endtask

    task automatic feed(input int a, input int b);
        for (int p = a; p < b; p++) send_pixel(p);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 800 && o_done !== 1'b1; k++) @(negedge clk);
        chk("done_seen", o_done, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (o_ctrl_start === 1'b1) n_ctrl++;
            if (o_func_start === 1'b1) n_func++;
            if (o_done === 1'b1) n_done++;
        end
    end

    // ctrl + crossbar responder; cim_hold stretches the crossbar phase, rst cuts it short.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (o_ctrl_start === 1'b1 && !rst) begin
                i_ctrl_busy = 1'b1;
                i_cim_busy  = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                i_ctrl_busy = 1'b0;
                n = $urandom_range(0, 3) + (cim_hold ? 60 : 0);
                for (int i = 0; i < n; i++) begin
                    if (rst) break;
                    @(negedge clk);
                end
                i_cim_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_func_start === 1'b1 && !rst) begin
                i_func_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                i_func_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0, f0, d0;
        bit  seen;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: nominal frame, window-open timing, i_start ignored mid-frame
        c0 = n_ctrl; f0 = n_func; d0 = n_done;
        start_frame();
        feed(0, 14);
        repeat (4) @(negedge clk);
        chk("no_ctrl_before_window", n_ctrl - c0, 0);
        send_pixel(14);
        chk("stall_after_window", o_stall, 1);
        seen = (o_ctrl_start === 1'b1);
        @(negedge clk);
        seen = seen | (o_ctrl_start === 1'b1);
        chk("ctrl_start_within_2", seen, 1);
        feed(15, 20);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("restart_ignored_busy", o_busy, 1);
        feed(20, NPIX);
        wait_done();
        chk("f1_ctrl_starts", n_ctrl - c0, exp_wins(NPIX));
        chk("f1_func_starts", n_func - f0, exp_wins(NPIX));
        chk("f1_dones",       n_done - d0, 1);
        chk("f1_win_cnt",     o_win_cnt,   NWIN);
        chk("f1_idle_busy",   o_busy,      0);
        chk("f1_idle_stall",  o_stall,     0);
        chk("f1_no_overrun",  o_overrun,   0);

        // Frame 2: next layer busy in FUNC_REQ, and an overrun write
        c0 = n_ctrl; f0 = n_func; d0 = n_done;
        start_frame();
        feed(0, 14);
        i_next_busy = 1'b1;
        send_pixel(14);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("next_busy_no_func_start", o_func_start, 0);
            chk("next_busy_stall",         o_stall,      1);
        end
        i_next_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | (o_func_start === 1'b1);
        end
        chk("func_start_after_next_idle", seen, 1);
        feed(15, 22);
        chk("stall_before_overrun", o_stall, 1);
        i_pixel_we = 1'b1;
        @(negedge clk);
        i_pixel_we = 1'b0;
        chk("overrun_set", o_overrun, 1);
        feed(22, NPIX - 1);
        chk("no_done_before_last_pix", n_done - d0, 0);
        send_pixel(NPIX - 1);
        wait_done();
        chk("f2_ctrl_starts",     n_ctrl - c0, exp_wins(NPIX));
        chk("f2_func_starts",     n_func - f0, exp_wins(NPIX));
        chk("f2_dones",           n_done - d0, 1);
        chk("f2_win_cnt",         o_win_cnt,   NWIN);
        chk("f2_overrun_sticky",  o_overrun,   1);

        // Frame 3: reset while the crossbar is running the second window
        d0 = n_done;
        start_frame();
        feed(0, 15);
        cim_hold = 1'b1;
        send_pixel(15);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            seen = (o_ctrl_start === 1'b1);
            if (!seen) @(negedge clk);
        end
        chk("f3_ctrl_start", seen, 1);
        repeat (12) @(negedge clk);
        chk("f3_cim_stall",   o_stall,   1);
        chk("f3_cim_win_cnt", o_win_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        cim_hold = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_done", n_done - d0, 0);
        chk("mid_rst_idle",    o_busy,      0);

        // Frame 4: full frame after the abort
        c0 = n_ctrl; f0 = n_func; d0 = n_done;
        start_frame();
        feed(0, NPIX);
        wait_done();
        chk("f4_ctrl_starts", n_ctrl - c0, exp_wins(NPIX));
        chk("f4_func_starts", n_func - f0, exp_wins(NPIX));
        chk("f4_dones",       n_done - d0, 1);
        chk("f4_win_cnt",     o_win_cnt,   NWIN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter img_width, default 28, meaning input image width/height in pixels (square image).
REQ-002 SHALL have parameter kernel_dim, default 5, meaning kernel edge N (NxN window, stride 1).
REQ-003 SHALL have derived parameter out_dim = img_width-kernel_dim+1, meaning output width/height.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port i_start, input, 1, meaning frame start pulse.
REQ-007 SHALL have port i_pixel_we, input, 1, meaning the previous layer writes one pixel (all channels) into the ibufs.
REQ-008 SHALL have port o_stall, output, 1, meaning the previous layer must not write.
REQ-009 SHALL have ports i_ctrl_busy, i_cim_busy, i_func_busy and i_next_busy, input, 1 each, meaning the busy flags of ctrl, the crossbar, func and the next layer.
REQ-010 SHALL have ports o_ctrl_start and o_func_start, output, 1 each, meaning single-cycle start pulses.
REQ-011 SHALL have port o_busy, output, 1, meaning a frame is in progress.
REQ-012 SHALL have port o_done, output, 1, meaning a one-cycle pulse after the last window's func completes.
REQ-013 SHALL have port o_overrun, output, 1, meaning sticky: a pixel was written while o_stall was high.
REQ-014 SHALL have port o_win_cnt, output, $clog2(out_dim**2+1), meaning windows completed in the current frame.

Function
REQ-015 SHALL track the raster position of the next pixel with counters col and row, each 0..img_width-1; col wraps to 0 and increments row.
REQ-016 SHALL accept a pixel only when i_pixel_we=1, o_busy=1 and o_stall=0.
REQ-017 SHALL ignore a pixel written while o_stall=1 or o_busy=0, leave the counters unchanged and set o_overrun.
REQ-018 SHALL treat an accepted pixel at row>=kernel_dim-1 and col>=kernel_dim-1 as completing a valid window; any other accepted pixel only advances the counters.
REQ-019 SHALL implement the FSM IDLE, FILL, CTRL_REQ, CTRL_ACK, CTRL_RUN, CIM_RUN, FUNC_REQ, FUNC_ACK, FUNC_RUN, DONE.
REQ-020 SHALL, in IDLE, hold o_busy=0 and move to FILL on i_start, clearing col, row and o_win_cnt.
REQ-021 SHALL, in FILL, hold o_stall=0 and move to CTRL_REQ the cycle after a valid-window pixel is accepted.
REQ-022 SHALL hold o_stall=1 in every state except IDLE and FILL, so the ibuf window is frozen until ctrl has consumed it.
REQ-023 SHALL, in CTRL_REQ, pulse o_ctrl_start for one cycle when i_ctrl_busy=0 and i_func_busy=0, then enter CTRL_ACK; otherwise it waits.
REQ-024 SHALL, in CTRL_ACK, wait for i_ctrl_busy=1 and then enter CTRL_RUN.
REQ-025 SHALL, in CTRL_RUN, wait for i_ctrl_busy=0 and then enter CIM_RUN.
REQ-026 SHALL, in CIM_RUN, wait at least one cycle and until i_cim_busy=0, then enter FUNC_REQ.
REQ-027 SHALL, in FUNC_REQ, pulse o_func_start for one cycle when i_next_busy=0 and i_func_busy=0, then enter FUNC_ACK.
REQ-028 SHALL, in FUNC_ACK, wait for i_func_busy=1, then enter FUNC_RUN.
REQ-029 SHALL, in FUNC_RUN, on i_func_busy=0, increment o_win_cnt and go to DONE if o_win_cnt becomes out_dim**2, else to FILL.
REQ-030 SHALL, in DONE, pulse o_done for one cycle and return to IDLE, holding o_win_cnt until the next i_start.
REQ-031 SHALL ignore i_start outside IDLE; no frame restart occurs mid-frame.
REQ-032 SHALL, for a pixel accepted in the same cycle as a state transition, count the pixel exactly once.
REQ-033 SHALL register all outputs: no combinational path from inputs to outputs.

Reset
REQ-034 SHALL, on rst, enter IDLE with col=row=0, o_win_cnt=0, o_overrun=0, o_busy=0, o_done=0, o_ctrl_start=0 and o_func_start=0, and o_stall=0 in IDLE.
REQ-035 SHALL let rst mid-frame abort the frame immediately, with no o_done.
REQ-036 SHALL give rst priority over every other input.

Structure
REQ-037 SHALL place the FSM state enum in the shared package conv_pkg.
REQ-038 SHALL provide the sub-module conv_pix_cnt for the col/row raster counter with a window-valid output.

Verification
REQ-039 SHALL check: img_width=6, kernel_dim=3, i_start, 36 pixels with ideal busy responders -> 16 o_ctrl_start, 16 o_func_start, one o_done, o_win_cnt=16.
REQ-040 SHALL check: the first 14 pixels (row 2, col 1 is the 14th) -> no o_ctrl_start; the 15th pixel (row 2, col 2) -> o_stall=1 the next cycle and o_ctrl_start within 2 cycles.
REQ-041 SHALL check: i_next_busy held high 20 cycles in FUNC_REQ -> no o_func_start until it drops, o_stall stays 1.
REQ-042 SHALL check: a pixel written while o_stall=1 -> o_overrun=1, pixel not counted, the total still requires 36 accepted pixels.
REQ-043 SHALL check: rst asserted in CIM_RUN -> next cycle IDLE, all outputs at reset values, no o_done; a new i_start then runs a full 16-window frame.
